// File: rtl/async_fifo_wr_arbiter_pkg.sv
// rtl/async_fifo_wr_arbiter_pkg.sv - shared types and fifo_data field layout for the write arbiter
package async_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // fifo_data layout is {id, last, payload}; the read-side demux uses the same offsets
  function automatic int fd_last_pos(input int data_width);
    return data_width;
  endfunction

  function automatic int fd_id_lsb(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int fd_width(input int id_w, input int data_width);
    return id_w + 1 + data_width;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// rtl/async_fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for the arbiter
interface async_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  import async_fifo_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int FD_W = fd_width(ID_W, DATA_WIDTH);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_enable;
  logic                          fifo_ready;
  logic                          fifo_valid;
  logic [FD_W-1:0]               fifo_data;
  logic                          busy;
  logic [ID_W-1:0]               grant_id;

  // Environment side: requesters plus the FIFO's ready
  modport master (
    output req_valid, req_last, req_data, req_enable, fifo_ready,
    input  req_ready, fifo_valid, fifo_data, busy, grant_id
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_last, req_data, req_enable, fifo_ready,
    output req_ready, fifo_valid, fifo_data, busy, grant_id
  );

endinterface

// File: rtl/async_fifo_wr_arbiter_rr_priority_pick.sv
// rtl/async_fifo_wr_arbiter_rr_priority_pick.sv - first set bit at or after a rotating pointer
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  int cand;

  // Scan rr_ptr_i, rr_ptr_i+1, ... with explicit wrap so non-power-of-two sizes work
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found_o && eligible_i[cand[ID_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// rtl/async_fifo_wr_arbiter.sv - round-robin burst-locked scheduler for one FIFO write port
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input logic                   clk_in,
  input logic                   reset_in,
  async_fifo_wr_arbiter_if.slave bus_io
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int LAST_POS = fd_last_pos(DATA_WIDTH);
  localparam int ID_LSB   = fd_id_lsb(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  arb_state_t             state_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        grant_id_q;
  logic [CNT_W-1:0]       burst_cnt_q;

  logic [NUM_REQ-1:0]     eligible;
  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
  logic                   cur_valid;
  logic                   cur_last;
  logic                   transfer;
  logic                   burst_end;
  logic [ID_W-1:0]        rr_next;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = bus_io.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign eligible = bus_io.req_valid & bus_io.req_enable;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  assign cur_valid = (state_q == GRANT) && bus_io.req_valid[grant_id_q];
  assign cur_last  = bus_io.req_last[grant_id_q];
  assign transfer  = cur_valid && bus_io.fifo_ready;
  // A forced split on the MAX_BURST-th beat leaves last=0; the packet resumes next grant
  assign burst_end = transfer && (cur_last || (burst_cnt_q == CNT_LAST));
  assign rr_next   = (grant_id_q == ID_MAX) ? '0 : grant_id_q + ID_W'(1);

  assign bus_io.fifo_valid = cur_valid;
  assign bus_io.busy       = (state_q == GRANT);
  assign bus_io.grant_id   = grant_id_q;

  // Only the granted requester sees the FIFO's ready, and only while in GRANT
  always_comb begin
    bus_io.req_ready = '0;
    if (state_q == GRANT) bus_io.req_ready[grant_id_q] = bus_io.fifo_ready;
  end

  // Tag the granted requester's beat with its ID and last flag
  always_comb begin
    bus_io.fifo_data                       = '0;
    bus_io.fifo_data[0 +: DATA_WIDTH]      = data_arr[grant_id_q];
    bus_io.fifo_data[LAST_POS]             = cur_last;
    bus_io.fifo_data[ID_LSB +: ID_W]       = grant_id_q;
  end

  // Arbitration FSM: one bubble cycle in IDLE, then pass-through until the burst ends
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q  <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (burst_end) begin
            rr_ptr_q <= rr_next;
            state_q  <= IDLE;
          end else if (transfer) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb/tb_async_fifo_wr_arbiter.sv - self-checking bench for async_fifo_wr_arbiter
module tb_async_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IW = 2;
  localparam int FW = IW + 1 + DW;

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  async_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  async_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus_io   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Requester sources: beats left in current packet, next payload value
  int              left      [NR];
  int              fixed_len [NR];
  logic [DW-1:0]   dcnt      [NR];

  // Reference model: is a grant held, to whom, beats so far, rotation pointer
  bit m_grant;
  int m_gid, m_cnt, m_ptr;

  logic            exp_valid;
  logic [NR-1:0]   exp_ready;
  logic            exp_busy;
  logic [FW-1:0]   exp_data;
  logic [IW-1:0]   exp_gid;

  int obs_id[$];
  bit obs_last[$];
  int obs_cyc[$];

  function automatic int new_len(input int i);
    return (fixed_len[i] > 0) ? fixed_len[i] : int'($urandom_range(1, 6));
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NR; i++) begin
      bus.req_last[i]           = (left[i] == 1);
      bus.req_data[i*DW +: DW]  = dcnt[i];
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < NR; i++) begin
      left[i] = new_len(i);
      dcnt[i] = DW'($urandom);
    end
    drive_srcs();
  endtask

  function automatic void predict();
    exp_gid   = m_gid[IW-1:0];
    exp_busy  = m_grant;
    exp_valid = m_grant && bus.req_valid[m_gid];
    exp_ready = '0;
    if (m_grant && bus.fifo_ready) exp_ready[m_gid] = 1'b1;
    exp_data  = {exp_gid, bus.req_last[m_gid], bus.req_data[m_gid*DW +: DW]};
  endfunction

  task automatic sample();
    @(negedge clk_in);
    cyc++;
    predict();
    if (bus.fifo_valid === 1'b1 && bus.fifo_ready === 1'b1) begin
      obs_id.push_back(int'(bus.fifo_data[FW-1 -: IW]));
      obs_last.push_back(bus.fifo_data[DW]);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic advance();
    bit hit;
    int c;
    @(posedge clk_in);
    if (reset_in) begin
      m_grant = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_grant) begin
      hit = 0;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (!hit && bus.req_valid[c] && bus.req_enable[c]) begin
          hit = 1; m_gid = c; m_cnt = 0; m_grant = 1;
        end
      end
    end else if (exp_valid && bus.fifo_ready) begin
      if (left[m_gid] == 1) left[m_gid] = new_len(m_gid);
      else left[m_gid] = left[m_gid] - 1;
      dcnt[m_gid] = dcnt[m_gid] + 1'b1;
      if (bus.req_last[m_gid] || m_cnt == MB - 1) begin
        m_ptr = (m_gid + 1) % NR;
        m_grant = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    drive_srcs();
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    model_reset();
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    obs_id.delete(); obs_last.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) fixed_len[i] = 1;
    bus.req_valid = '1; bus.req_enable = '1; bus.fifo_ready = 1'b1;
    reset_in = 1'b1;
    model_reset();
    obs_id.delete(); obs_last.delete(); obs_cyc.delete();
    sample();
    checks++;
    if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%b busy=%b gid=%0d want all 0",
               bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id);
    end
    advance();
    reset_in = 1'b0;
    for (int n = 0; n < 3; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL reset_release_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int want_ids[5] = '{0, 1, 2, 3, 0};
    for (int n = 0; n < 10; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL rr_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.fifo_data !== exp_data) begin
          errors++;
          $display("FAIL rr_data cyc %0d got %h want %h", cyc, bus.fifo_data, exp_data);
        end
      end
      advance();
    end
    checks++;
    if (obs_id.size() < 5) begin
      errors++;
      $display("FAIL rr_beat_count got %0d want >=5", obs_id.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_id[i] != want_ids[i]) begin
          errors++;
          $display("FAIL rr_order beat %0d got id %0d want %0d", i, obs_id[i], want_ids[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL rr_bubble beat %0d got gap %0d want 2", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_burst_lock();
    int  want_ids[6]  = '{2, 2, 2, 2, 2, 0};
    bit  want_last[6] = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < NR; i++) fixed_len[i] = 1;
    fixed_len[2] = 5;
    bus.req_valid = 4'b0100; bus.req_enable = '1; bus.fifo_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL burst_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.fifo_data !== exp_data) begin
          errors++;
          $display("FAIL burst_data cyc %0d got %h want %h", cyc, bus.fifo_data, exp_data);
        end
      end
      advance();
      bus.req_valid = 4'b0101;
    end
    checks++;
    if (obs_id.size() < 6) begin
      errors++;
      $display("FAIL burst_beat_count got %0d want >=6", obs_id.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_id[i] != want_ids[i] || obs_last[i] != want_last[i]) begin
          errors++;
          $display("FAIL burst_seq beat %0d got id %0d last %0d want id %0d last %0d",
                   i, obs_id[i], obs_last[i], want_ids[i], want_last[i]);
        end
      end
    end
  endtask

  task automatic test_forced_split();
    for (int i = 0; i < NR; i++) fixed_len[i] = 1;
    fixed_len[1] = 20;
    bus.req_valid = 4'b0010; bus.req_enable = '1; bus.fifo_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL split_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.fifo_data !== exp_data) begin
          errors++;
          $display("FAIL split_data cyc %0d got %h want %h", cyc, bus.fifo_data, exp_data);
        end
      end
      advance();
    end
    checks++;
    if (obs_id.size() < 20) begin
      errors++;
      $display("FAIL split_beat_count got %0d want >=20", obs_id.size());
    end else begin
      checks++;
      if (obs_last[15] != 1'b0 || obs_last[19] != 1'b1 || obs_id[15] != 1 || obs_id[19] != 1) begin
        errors++;
        $display("FAIL split_last got b16 last %0d b20 last %0d want 0 and 1", obs_last[15], obs_last[19]);
      end
      checks++;
      if (obs_cyc[16] - obs_cyc[15] != 2 || obs_cyc[15] - obs_cyc[0] != 15) begin
        errors++;
        $display("FAIL split_timing got gaps %0d/%0d want 2/15",
                 obs_cyc[16] - obs_cyc[15], obs_cyc[15] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic prev_ready;
    logic [3:0] pat = 4'b1001;
    for (int i = 0; i < NR; i++) fixed_len[i] = 0;
    bus.req_valid = '1; bus.req_enable = '1; bus.fifo_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL bp_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.fifo_data !== exp_data) begin
          errors++;
          $display("FAIL bp_data cyc %0d got %h want %h", cyc, bus.fifo_data, exp_data);
        end
      end
      advance();
      prev_ready = bus.fifo_ready;
      if (n < 8) bus.fifo_ready = pat[n % 4];
      else bus.fifo_ready = ($urandom_range(0, 2) != 0);
      bus.req_valid  = NR'($urandom) | (n < 8 ? 4'b0001 : 4'b0000);
      bus.req_enable = NR'($urandom) | 4'b0011;
    end
  endtask

  task automatic test_mask_reset();
    int hits3;
    for (int i = 0; i < NR; i++) fixed_len[i] = 1;
    bus.req_valid = '1; bus.req_enable = 4'b0111; bus.fifo_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL mask_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      advance();
      bus.fifo_ready = ($urandom_range(0, 3) != 0);
    end
    hits3 = 0;
    foreach (obs_id[i]) if (obs_id[i] == 3) hits3++;
    checks++;
    if (hits3 != 0 || obs_id.size() == 0) begin
      errors++;
      $display("FAIL mask_excluded got %0d id3 beats of %0d want 0 of >0", hits3, obs_id.size());
    end
    // Move the pointer to 3, then start a long req 1 burst and reset in the middle of it
    fixed_len[1] = 10;
    bus.req_valid = 4'b0100; bus.req_enable = '1; bus.fifo_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      sample();
      advance();
      if (n == 1) bus.req_valid = 4'b0010;
    end
    reset_in = 1'b1;
    m_grant = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    sample();
    checks++;
    if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
      errors++;
      $display("FAIL midreset_ctrl got %b%b%b%0d want %b%b%b%0d",
               bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
    end
    advance();
    reset_in = 1'b0;
    model_reset();
    bus.req_valid = 4'b1001;
    obs_id.delete(); obs_last.delete(); obs_cyc.delete();
    for (int n = 0; n < 4; n++) begin
      sample();
      checks++;
      if ({bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id} !== {exp_valid, exp_ready, exp_busy, exp_gid}) begin
        errors++;
        $display("FAIL postreset_ctrl cyc %0d got %b%b%b%0d want %b%b%b%0d", cyc,
                 bus.fifo_valid, bus.req_ready, bus.busy, bus.grant_id, exp_valid, exp_ready, exp_busy, exp_gid);
      end
      advance();
    end
    checks++;
    if (obs_id.size() == 0 || obs_id[0] != 0) begin
      errors++;
      $display("FAIL postreset_first_id got %0d (beats %0d) want 0",
               (obs_id.size() > 0) ? obs_id[0] : -1, obs_id.size());
    end
  endtask

  initial begin
    reset_in       = 1'b1;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.req_enable = '1;
    bus.fifo_ready = 1'b0;
    for (int i = 0; i < NR; i++) fixed_len[i] = 1;
    model_reset();
    @(posedge clk_in);
    #1;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_forced_split();
    test_backpressure();
    test_mask_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Write-side scheduler sharing one async FIFO write port among NUM_REQ requesters, all in the clk_in domain.
- Round-robin arbitration with burst lock: a granted requester keeps the port until it sends a `last` beat or hits MAX_BURST beats.
- Each beat is tagged with requester ID and `last` flag so the read domain can demultiplex.
- Sits directly in front of the FIFO's ready_in/valid_in/data_in.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, payload width per requester.
- MAX_BURST, 16, max beats per grant before forced rotation (>=1).
- ID_W, $clog2(NUM_REQ), requester ID width (derived localparam).

Ports:
- clk_in  input  1  write-domain clock.
- reset_in  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_ready  output  NUM_REQ  per-requester beat accepted.
- req_last  input  NUM_REQ  per-requester end-of-packet flag.
- req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_enable  input  NUM_REQ  arbitration mask; 0 excludes a requester from new grants.
- fifo_ready  input  1  FIFO write-side ready (not full).
- fifo_valid  output  1  beat to FIFO valid.
- fifo_data  output  ID_W+1+DATA_WIDTH  {grant_id, last, payload}.
- busy  output  1  high while in GRANT state.
- grant_id  output  ID_W  current or last granted requester.

Behaviour:
Reset (async, reset_in=1):
- state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
- req_ready=0, fifo_valid=0, busy=0.

States:
- IDLE
  - Eligible set = req_valid & req_enable.
  - If non-empty, pick the first eligible index scanning from rr_ptr upward with wrap (rr_ptr itself has highest priority).
  - Register grant_id, clear burst_cnt, go to GRANT.
  - No beat transfers in IDLE: one-cycle arbitration bubble.
- GRANT (pass-through, combinational)
  - fifo_valid = req_valid[grant_id].
  - req_ready[grant_id] = fifo_ready; all other req_ready bits = 0.
  - fifo_data = {grant_id, req_last[grant_id], req_data slice}.
  - Beat transfers when fifo_valid && fifo_ready; each transfer increments burst_cnt.
  - Burst ends on a transferred beat with last=1, or when burst_cnt reaches MAX_BURST-1 on a transfer (i.e. the MAX_BURST-th beat).
  - On burst end: rr_ptr = grant_id+1 mod NUM_REQ, state=IDLE.
  - Forced split keeps the original last bit (0) on the final beat; the packet resumes on that requester's next grant.

Boundary rules:
- Granted requester deasserts valid mid-burst: stay in GRANT, wait; no timeout.
- fifo_ready=0: hold; req_ready all 0, fifo_data tracks the granted requester's inputs.
- req_enable changes are sampled only in IDLE; a grant in progress completes regardless.
- New requests arriving during GRANT wait for IDLE; at the burst-end cycle the next arbitration happens in the following IDLE cycle.
- Sustained throughput to one requester: MAX_BURST beats per MAX_BURST+1 cycles.
- MAX_BURST=1: every beat rotates.
- Index wrap: rr_ptr after NUM_REQ-1 is 0; the rr_ptr arithmetic must be correct for non-power-of-two NUM_REQ.
- reset_in asserted mid-burst: immediate return to reset state; a partially sent packet is abandoned, and the reader must resync on ID/last.

Decomposition:
- Package async_fifo_pkg:
  - state enum arb_state_t {IDLE, GRANT}.
  - Helper function for fifo_data field packing/unpacking (ID, last, payload offsets), shared with the read-side demux.
- One sub-module rr_priority_pick (NUM_REQ): inputs eligible mask and rr_ptr; outputs found flag and index. Combinational, reusable by other schedulers.
- Top-level holds the FSM, burst counter and muxing.

Test Plan:
1. Reset check: reset_in pulse with all req_valid=1 -> req_ready=0, fifo_valid=0, busy=0 during reset; first grant goes to ID 0 two edges after release.
2. Round-robin: all four valid with single-beat last=1 packets, fifo_ready=1 -> fifo_data IDs in order 0,1,2,3,0; one bubble cycle between beats.
3. Burst lock: req 2 sends 5-beat packet, req 0 valid throughout -> five consecutive ID-2 beats, last only on beat 5, then ID 0.
4. Forced split: MAX_BURST=16, req 1 sends a 20-beat packet with others idle -> 16 beats, bubble, re-grant to req 1 (only eligible), remaining 4 beats with last on beat 20.
5. Backpressure: fifo_ready toggles 1,0,0,1 mid-burst -> req_ready mirrors fifo_ready, no beat lost or duplicated, burst_cnt advances only on transfers.
6. Mask and mid-burst reset: req_enable[3]=0 with req 3 valid -> never granted; assert reset_in during a req 1 burst -> outputs zero in the same cycle, rr_ptr=0 after release.
